// File: rtl/wb_regfile.sv
// Writeback-stage register file.
//
// Holds 2**ADDR_W architectural registers of DATA_W bits, written from the EX/WB pipeline
// register and read combinationally by decode. A same-cycle writeback is bypassed onto
// the read ports so decode never needs to stall on it. Register 0 is hardwired to zero.
//
// Ports:
//   Clk              clock, rising-edge active
//   Reset            asynchronous, active-low reset
//   RegWrite_EX_WB   write enable from EX/WB
//   Rd_EX_WB         destination register index
//   ALUresult_EX_WB  write data
//   Rs1, Rs2         decode read indices
//   RD1, RD2         decode read data (with write bypass)
//   Dbg_Addr         debug read index
//   Dbg_Data         debug read data, committed state only (no bypass)
//   WrCount          count of committed writes, wraps modulo 2**CNT_W
//   WrValid          high the cycle after a committed write
//   WrAddrLast       index of the last committed write
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RegWrite_EX_WB,
  input  logic [ADDR_W-1:0] Rd_EX_WB,
  input  logic [DATA_W-1:0] ALUresult_EX_WB,
  input  logic [ADDR_W-1:0] Rs1,
  input  logic [ADDR_W-1:0] Rs2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic [ADDR_W-1:0] Dbg_Addr,
  output logic [DATA_W-1:0] Dbg_Data,
  output logic [CNT_W-1:0]  WrCount,
  output logic              WrValid,
  output logic [ADDR_W-1:0] WrAddrLast
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  // Flop array rather than RAM so the whole file can be cleared asynchronously.
  logic [DATA_W-1:0] regs_q [Depth];
  logic [CNT_W-1:0]  wr_count_q;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_last_q;

  logic commit;
  logic bypass1, bypass2;

  assign commit = RegWrite_EX_WB && (Rd_EX_WB != '0);

  // Bypass is suppressed while in reset so read ports show the cleared array.
  assign bypass1 = commit && Reset && (Rd_EX_WB == Rs1);
  assign bypass2 = commit && Reset && (Rd_EX_WB == Rs2);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[Rd_EX_WB] <= ALUresult_EX_WB;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_count_q     <= '0;
      wr_valid_q     <= 1'b0;
      wr_addr_last_q <= '0;
    end else begin
      wr_valid_q <= commit;
      if (commit) begin
        wr_count_q     <= wr_count_q + CNT_W'(1);
        wr_addr_last_q <= Rd_EX_WB;
      end
    end
  end

  always_comb begin
    RD1 = regs_q[Rs1];
    if (Rs1 == '0) begin
      RD1 = '0;
    end else if (bypass1) begin
      RD1 = ALUresult_EX_WB;
    end
  end

  always_comb begin
    RD2 = regs_q[Rs2];
    if (Rs2 == '0) begin
      RD2 = '0;
    end else if (bypass2) begin
      RD2 = ALUresult_EX_WB;
    end
  end

  // Entry 0 is never written, so the raw array already reads 0 there.
  assign Dbg_Data   = regs_q[Dbg_Addr];
  assign WrCount    = wr_count_q;
  assign WrValid    = wr_valid_q;
  assign WrAddrLast = wr_addr_last_q;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        Clk;
  logic        Reset;
  logic        RegWrite_EX_WB;
  logic [4:0]  Rd_EX_WB;
  logic [31:0] ALUresult_EX_WB;
  logic [4:0]  Rs1, Rs2, Dbg_Addr;
  logic [31:0] RD1, RD2, Dbg_Data;
  logic [15:0] WrCount;
  logic        WrValid;
  logic [4:0]  WrAddrLast;

  // Second instance with a narrow counter for the wrap test.
  logic        we4;
  logic [4:0]  rd4;
  logic [31:0] data4;
  logic [31:0] rd1_4, rd2_4, dbg_4;
  logic [3:0]  cnt4;
  logic        valid4;
  logic [4:0]  last4;

  int errors = 0;
  int checks = 0;

  wb_regfile u_dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .RegWrite_EX_WB  (RegWrite_EX_WB),
    .Rd_EX_WB        (Rd_EX_WB),
    .ALUresult_EX_WB (ALUresult_EX_WB),
    .Rs1             (Rs1),
    .Rs2             (Rs2),
    .RD1             (RD1),
    .RD2             (RD2),
    .Dbg_Addr        (Dbg_Addr),
    .Dbg_Data        (Dbg_Data),
    .WrCount         (WrCount),
    .WrValid         (WrValid),
    .WrAddrLast      (WrAddrLast)
  );

  wb_regfile #(.CNT_W(4)) u_dut4 (
    .Clk             (Clk),
    .Reset           (Reset),
    .RegWrite_EX_WB  (we4),
    .Rd_EX_WB        (rd4),
    .ALUresult_EX_WB (data4),
    .Rs1             (5'd0),
    .Rs2             (5'd0),
    .RD1             (rd1_4),
    .RD2             (rd2_4),
    .Dbg_Addr        (rd4),
    .Dbg_Data        (dbg_4),
    .WrCount         (cnt4),
    .WrValid         (valid4),
    .WrAddrLast      (last4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  dbg;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_dbg;
    logic [15:0] exp_cnt;
    logic        exp_valid;
    logic [4:0]  exp_last;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Inputs applied just after an edge, checked 2 time units later (before the next edge).
    // Registered expectations reflect state before that vector's edge.
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'd5,
                32'hDEADBEEF, 32'h0, 32'h0, 16'd0, 1'b0, 5'd0};
    vecs[1] = '{1'b1, 5'd31, 32'h12345678, 5'd5,  5'd31, 5'd5,
                32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 16'd1, 1'b1, 5'd5};
    vecs[2] = '{1'b0, 5'd31, 32'hAAAA5555, 5'd5,  5'd31, 5'd31,
                32'hDEADBEEF, 32'h12345678, 32'h12345678, 16'd2, 1'b1, 5'd31};
    vecs[3] = '{1'b1, 5'd7,  32'h00000001, 5'd0,  5'd7,  5'd7,
                32'h0, 32'h1, 32'h0, 16'd2, 1'b0, 5'd31};
    vecs[4] = '{1'b1, 5'd7,  32'hCAFEF00D, 5'd7,  5'd7,  5'd7,
                32'hCAFEF00D, 32'hCAFEF00D, 32'h1, 16'd3, 1'b1, 5'd7};
    vecs[5] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  5'd7,
                32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 16'd4, 1'b1, 5'd7};
    vecs[6] = '{1'b0, 5'd7,  32'h00000000, 5'd0,  5'd5,  5'd0,
                32'h0, 32'hDEADBEEF, 32'h0, 16'd4, 1'b0, 5'd7};
    vecs[7] = '{1'b0, 5'd5,  32'h00000055, 5'd31, 5'd5,  5'd31,
                32'h12345678, 32'hDEADBEEF, 32'h12345678, 16'd4, 1'b0, 5'd7};

    Reset = 1'b0;
    RegWrite_EX_WB = 1'b0;
    Rd_EX_WB = '0;
    ALUresult_EX_WB = '0;
    Rs1 = '0;
    Rs2 = '0;
    Dbg_Addr = '0;
    we4 = 1'b0;
    rd4 = '0;
    data4 = '0;

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      Dbg_Addr = 5'(i);
      #1;
      chk($sformatf("reset_dbg[%0d]", i), Dbg_Data, 32'h0);
    end
    chk("reset_cnt", 32'(WrCount), 32'h0);
    chk("reset_valid", 32'(WrValid), 32'h0);
    chk("reset_last", 32'(WrAddrLast), 32'h0);

    tick();
    for (int v = 0; v < 8; v++) begin
      RegWrite_EX_WB  = vecs[v].we;
      Rd_EX_WB        = vecs[v].rd;
      ALUresult_EX_WB = vecs[v].wdata;
      Rs1             = vecs[v].rs1;
      Rs2             = vecs[v].rs2;
      Dbg_Addr        = vecs[v].dbg;
      #2;
      chk($sformatf("v%0d_rd1", v), RD1, vecs[v].exp_rd1);
      chk($sformatf("v%0d_rd2", v), RD2, vecs[v].exp_rd2);
      chk($sformatf("v%0d_dbg", v), Dbg_Data, vecs[v].exp_dbg);
      chk($sformatf("v%0d_cnt", v), 32'(WrCount), 32'(vecs[v].exp_cnt));
      chk($sformatf("v%0d_valid", v), 32'(WrValid), 32'(vecs[v].exp_valid));
      chk($sformatf("v%0d_last", v), 32'(WrAddrLast), 32'(vecs[v].exp_last));
      tick();
    end
    RegWrite_EX_WB = 1'b0;

    // Narrow counter wraps 15 -> 0 -> 1 over 17 commits.
    for (int i = 0; i < 17; i++) begin
      we4   = 1'b1;
      rd4   = 5'(1 + (i % 31));
      data4 = 32'(i) + 32'h100;
      tick();
      chk($sformatf("wrap_cnt[%0d]", i), 32'(cnt4), 32'((i + 1) % 16));
    end
    we4 = 1'b0;
    chk("wrap_valid", 32'(valid4), 32'h1);
    chk("wrap_dbg", dbg_4, 32'h110);
    tick();
    chk("wrap_valid_drop", 32'(valid4), 32'h0);

    // Async reset between edges clears everything with no clock.
    Rs1 = 5'd5;
    Rs2 = 5'd31;
    Dbg_Addr = 5'd7;
    #1;
    chk("pre_rst_rd1", RD1, 32'hDEADBEEF);
    #1;
    Reset = 1'b0;
    #1;
    chk("rst_rd1", RD1, 32'h0);
    chk("rst_rd2", RD2, 32'h0);
    chk("rst_dbg", Dbg_Data, 32'h0);
    chk("rst_cnt", 32'(WrCount), 32'h0);
    chk("rst_cnt4", 32'(cnt4), 32'h0);
    chk("rst_last", 32'(WrAddrLast), 32'h0);

    // A write presented on an edge while in reset is lost.
    RegWrite_EX_WB  = 1'b1;
    Rd_EX_WB        = 5'd9;
    ALUresult_EX_WB = 32'h99999999;
    Dbg_Addr        = 5'd9;
    tick();
    RegWrite_EX_WB = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("rst_write_lost", Dbg_Data, 32'h0);
    chk("rst_write_cnt", 32'(WrCount), 32'h0);
    chk("rst_write_valid", 32'(WrValid), 32'h0);

    // First write after release commits normally.
    RegWrite_EX_WB  = 1'b1;
    Rd_EX_WB        = 5'd9;
    ALUresult_EX_WB = 32'h0BADF00D;
    tick();
    RegWrite_EX_WB = 1'b0;
    #1;
    chk("post_rst_dbg", Dbg_Data, 32'h0BADF00D);
    chk("post_rst_cnt", 32'(WrCount), 32'h1);
    chk("post_rst_valid", 32'(WrValid), 32'h1);
    chk("post_rst_last", 32'(WrAddrLast), 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
